// File: rtl/fifo_rr_ctrl_pkg.sv
// Shared definitions for the round-robin FIFO write-port controller:
// ID width helper, default geometry and the stored entry layout.
package fifo_pkg;

  // Source ID width: enough bits to name every producer, never less than one.
  function automatic int id_width(input int nreq);
    int w;
    w = $clog2(nreq);
    if (w < 1) begin
      return 1;
    end else begin
      return w;
    end
  endfunction

  // Number of entries addressed by an address of the given width.
  function automatic int depth_of(input int addrsize);
    return 1 << addrsize;
  endfunction

  localparam int DATASIZE_DEF  = 8;
  localparam int ADDRSIZE_DEF  = 4;
  localparam int NREQ_DEF      = 4;
  localparam int AFULL_LVL_DEF = 12;
  localparam int IDW_DEF       = id_width(NREQ_DEF);
  localparam int DEPTH_DEF     = depth_of(ADDRSIZE_DEF);

  // Stored word for the default geometry: source ID above the payload.
  typedef struct packed {
    logic [IDW_DEF-1:0]      id;
    logic [DATASIZE_DEF-1:0] data;
  } entry_t;

endpackage

// File: rtl/fifo_rr_ctrl_if.sv
// Producer, consumer and memory-side signals of the FIFO controller.
// slave: the controller itself; master: the parent that owns producers,
// the consumer and the storage array.
interface fifo_rr_ctrl_if #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4,
  parameter int NREQ     = 4
);
  localparam int IDW = fifo_pkg::id_width(NREQ);

  logic [NREQ-1:0]          req_valid;
  logic [NREQ*DATASIZE-1:0] req_data;
  logic [NREQ-1:0]          req_ready;
  logic [IDW+DATASIZE-1:0]  mem_wdata;
  logic [ADDRSIZE-1:0]      mem_waddr;
  logic                     mem_wclken;
  logic                     mem_wfull;
  logic [ADDRSIZE-1:0]      mem_raddr;
  logic [IDW+DATASIZE-1:0]  mem_rdata;
  logic                     rd_valid;
  logic                     rd_ready;
  logic [DATASIZE-1:0]      rd_data;
  logic [IDW-1:0]           rd_id;
  logic [ADDRSIZE:0]        count;
  logic                     almost_full;

  modport slave (
    input  req_valid, req_data, mem_rdata, rd_ready,
    output req_ready, mem_wdata, mem_waddr, mem_wclken, mem_wfull,
           mem_raddr, rd_valid, rd_data, rd_id, count, almost_full
  );

  modport master (
    output req_valid, req_data, mem_rdata, rd_ready,
    input  req_ready, mem_wdata, mem_waddr, mem_wclken, mem_wfull,
           mem_raddr, rd_valid, rd_data, rd_id, count, almost_full
  );

endinterface

// File: rtl/fifo_rr_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the priority
// pointer; the pointer moves past the winner only when the grant is used.
module rr_arbiter
  import fifo_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = id_width(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id
);

  logic [IDW-1:0] rr_r;
  logic [IDW-1:0] rr_nxt_s;
  logic           found_s;

  // Requester index base+off, wrapped into 0..NREQ-1.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) begin
      s = s - NREQ;
    end else begin
      s = s;
    end
    return IDW'(s);
  endfunction

  // Scan requesters starting at the priority pointer; first hit wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found_s  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found_s && req[wrap_idx(rr_r, k)]) begin
        found_s                  = 1'b1;
        grant[wrap_idx(rr_r, k)] = 1'b1;
        grant_id                 = wrap_idx(rr_r, k);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Priority pointer after a used grant: one past the winner, modulo NREQ.
  always_comb begin
    if (int'(grant_id) == NREQ - 1) begin
      rr_nxt_s = '0;
    end else begin
      rr_nxt_s = grant_id + IDW'(1);
    end
  end

  // Priority pointer register; holds when no grant is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_r <= '0;
    end else if (en) begin
      rr_r <= rr_nxt_s;
    end else begin
      rr_r <= rr_r;
    end
  end

endmodule

// File: rtl/fifo_rr_ctrl.sv
// FIFO write-port controller: round-robin sharing of one memory write port
// among NREQ producers, pointer/flag bookkeeping, show-ahead pop interface.
module fifo_rr_ctrl
  import fifo_pkg::*;
#(
  parameter int DATASIZE  = 8,
  parameter int ADDRSIZE  = 4,
  parameter int NREQ      = 4,
  parameter int AFULL_LVL = 12
) (
  input logic           clk,
  input logic           rst,
  fifo_rr_ctrl_if.slave bus
);

  localparam int IDW = id_width(NREQ);
  localparam int PW  = ADDRSIZE + 1;

  typedef struct packed {
    logic [IDW-1:0]      id;
    logic [DATASIZE-1:0] data;
  } wr_entry_t;

  logic [PW-1:0]   wptr_r, rptr_r, count_r;
  logic [PW-1:0]   wptr_nxt_s, rptr_nxt_s, count_nxt_s;
  logic            full_r, rd_valid_r, afull_r;
  logic            full_nxt_s, rd_valid_nxt_s, afull_nxt_s;
  logic [NREQ-1:0] grant_s;
  logic [IDW-1:0]  grant_id_s;
  logic            push_s, pop_s;
  wr_entry_t       wr_entry_s;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (bus.req_valid),
    .en       (push_s),
    .grant    (grant_s),
    .grant_id (grant_id_s)
  );

  // Accept/pop qualification and write-port drive; a full FIFO refuses
  // pushes even when a pop frees a slot at the same edge.
  always_comb begin
    push_s     = (|bus.req_valid) & ~full_r & ~rst;
    pop_s      = rd_valid_r & bus.rd_ready;
    wr_entry_s = '0;
    wr_entry_s.id = grant_id_s;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_s[i]) begin
        wr_entry_s.data = bus.req_data[i*DATASIZE +: DATASIZE];
      end else begin
        wr_entry_s.data = wr_entry_s.data;
      end
    end
    if (rst) begin
      bus.req_ready = '0;
    end else begin
      bus.req_ready = grant_s & {NREQ{~full_r}};
    end
    bus.mem_wclken = push_s;
    bus.mem_wdata  = wr_entry_s;
  end

  // Next pointers and the flags they imply, so flags register alongside.
  always_comb begin
    if (push_s) begin
      wptr_nxt_s = wptr_r + PW'(1);
    end else begin
      wptr_nxt_s = wptr_r;
    end
    if (pop_s) begin
      rptr_nxt_s = rptr_r + PW'(1);
    end else begin
      rptr_nxt_s = rptr_r;
    end
    count_nxt_s    = wptr_nxt_s - rptr_nxt_s;
    full_nxt_s     = (wptr_nxt_s[ADDRSIZE] != rptr_nxt_s[ADDRSIZE]) &&
                     (wptr_nxt_s[ADDRSIZE-1:0] == rptr_nxt_s[ADDRSIZE-1:0]);
    rd_valid_nxt_s = (wptr_nxt_s != rptr_nxt_s);
    afull_nxt_s    = (count_nxt_s >= PW'(AFULL_LVL));
  end

  // Pointer and flag registers; reset discards everything stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_r     <= '0;
      rptr_r     <= '0;
      count_r    <= '0;
      full_r     <= 1'b0;
      rd_valid_r <= 1'b0;
      afull_r    <= 1'b0;
    end else begin
      wptr_r     <= wptr_nxt_s;
      rptr_r     <= rptr_nxt_s;
      count_r    <= count_nxt_s;
      full_r     <= full_nxt_s;
      rd_valid_r <= rd_valid_nxt_s;
      afull_r    <= afull_nxt_s;
    end
  end

  assign bus.mem_waddr   = wptr_r[ADDRSIZE-1:0];
  assign bus.mem_raddr   = rptr_r[ADDRSIZE-1:0];
  assign bus.mem_wfull   = full_r;
  assign bus.rd_valid    = rd_valid_r;
  assign bus.count       = count_r;
  assign bus.almost_full = afull_r;
  assign bus.rd_data     = bus.mem_rdata[DATASIZE-1:0];
  assign bus.rd_id       = bus.mem_rdata[DATASIZE +: IDW];

endmodule

// File: doc/fifo_rr_ctrl.md
# fifo_rr_ctrl

Single-clock controller that shares the write port of the `fifo_memory` storage array among `NREQ` producers using round-robin arbitration. It also owns the write/read pointers, full/empty/almost-full flags and occupancy count. The consumer side gets a show-ahead valid/ready pop interface.
- Each stored entry is the producer's data plus its source ID, so the consumer knows which requester wrote it.
- The block sits between the producer interfaces and a `fifo_memory` instance with `DATASIZE = DATASIZE + IDW`.

## Interface
Parameters:
- `DATASIZE`, default 8: payload width per producer.
- `ADDRSIZE`, default 4: memory address width; `DEPTH = 2**ADDRSIZE`.
- `NREQ`, default 4: number of producers, at least 2.
- `AFULL_LVL`, default 12: `almost_full` asserts when `count >= AFULL_LVL`.

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  producer i has a word.
- `req_data`  in  NREQ*DATASIZE  producer i data in slice i.
- `req_ready`  out  NREQ  word from producer i accepted this cycle.
- `mem_wdata`  out  IDW+DATASIZE  {grant_id, data} to memory.
- `mem_waddr`  out  ADDRSIZE  write address.
- `mem_wclken`  out  1  write enable.
- `mem_wfull`  out  1  full flag to memory.
- `mem_raddr`  out  ADDRSIZE  read address.
- `mem_rdata`  in  IDW+DATASIZE  combinational read data from memory.
- `rd_valid`  out  1  FIFO not empty.
- `rd_ready`  in  1  consumer pops when high with `rd_valid`.
- `rd_data`  out  DATASIZE  head payload.
- `rd_id`  out  IDW  head source ID.
- `count`  out  ADDRSIZE+1  occupancy, 0..DEPTH.
- `almost_full`  out  1  `count >= AFULL_LVL`.

`IDW = max(1, $clog2(NREQ))`.

## Operation
- Pointers `wptr` and `rptr` are ADDRSIZE+1 bits wide. Addresses are the low ADDRSIZE bits. Pointers wrap naturally modulo `2**(ADDRSIZE+1)`.
- Flags: `empty = (wptr == rptr)`. `full` = MSBs differ and low bits equal.
- `count = wptr - rptr`, computed modulo ADDRSIZE+1 bits.
- Arbiter: round-robin priority pointer `rr`, reset value 0. The winner is the first asserted `req_valid` at index `rr`, `rr+1`, … (mod NREQ).
- Grant is combinational. `req_ready[i] = grant[i] & !full`, so at most one bit of `req_ready` is high.
- Push, when `|req_valid & !full`:
  - `mem_wclken = 1` and `mem_wdata = {id, req_data[id]}`.
  - `wptr` increments.
  - `rr` becomes `id+1` mod NREQ.
- When no push occurs, `rr` holds.
- Pop, when `rd_valid & rd_ready`: `rptr` increments.
- `rd_data`/`rd_id` come from `mem_rdata` at `mem_raddr = rptr[ADDRSIZE-1:0]`. They are don't-care while `rd_valid = 0`.
- Full: `req_ready` is all zeros even if a pop happens in the same cycle. The push is not accepted; the producer retries the next cycle.
- Empty with simultaneous push: no fall-through. `rd_valid` rises the cycle after the push.
- Simultaneous push and pop when neither full nor empty: both pointers advance and `count` is unchanged.
- `rd_ready` while empty is ignored. No overflow or underflow state is possible.
- `mem_wfull` drives `full` straight through; the memory's own guard is redundant by design.

## Timing
- Reset (asynchronous, any cycle, including mid-burst):
  - `wptr = rptr = 0`, `rr = 0`, `count = 0`.
  - `rd_valid = 0`, `almost_full = 0`, `mem_wfull = 0`.
  - `req_ready = 0` while `rst` is high.
  - Contents in flight are discarded.
- Push-to-visible latency is 1 cycle: a word accepted at edge N is readable with `rd_valid = 1` after edge N.
- The pop takes effect at the edge; the next head is presented combinationally after that edge.
- All outputs are registered pointer/flag state, except `req_ready`, `mem_wclken`, `mem_wdata` and `rd_data`/`rd_id`. These are combinational from current inputs and state.
- Sustained throughput: one push and one pop per cycle.

## Structure
- Package `fifo_pkg` holds:
  - `id_width(NREQ)` function.
  - Typedef for the stored entry struct {id, data}.
  - Flag helper constants, e.g. `DEPTH`.
- One sub-module, `rr_arbiter`, parameterized on `NREQ`:
  - Inputs: `req`, `en` (advance).
  - Outputs: one-hot `grant`, binary `grant_id`.
  - Owns the `rr` register.
- `fifo_rr_ctrl` holds the pointers and flags and instantiates `rr_arbiter`. The `fifo_memory` instance lives in the parent.

## Test plan
- Reset mid-stream: `rst` asserted while 5 entries stored → next cycle `count = 0`, `rd_valid = 0`, `req_ready = 0`. After release, first grant goes to requester 0.
- Fairness: all 4 `req_valid` held high for 8 cycles, consumer idle → grant order 0,1,2,3,0,1,2,3. Popped `rd_id` sequence matches.
- Fill to full: single requester 2 streams 0x00..0x10 → 16 accepted. `almost_full` rises when `count` reaches 12. `req_ready` drops with `count = 16`; word 0x10 is held off until a pop.
- Full with simultaneous pop: at `count = 16`, `rd_ready = 1` and `req_valid[1] = 1` → pop succeeds, push refused, `count = 15`. Next cycle the push is accepted and `count = 16`.
- Wrap-around: 40 push/pop pairs at 1/cycle with data = index → `count` stays at 1 throughout. Data is returned in order across two pointer wraps.
- Empty push: empty FIFO, push 0xA5 from requester 3 → `rd_valid = 0` that cycle. Next cycle `rd_valid = 1`, `rd_data = 0xA5`, `rd_id = 3`.
